// File: rtl/imm_ext_pipe.sv
// Registered immediate extender: picks a 5/8/11-bit (or full-width) field and sign/zero-extends it.
// One cycle from accept to out_valid; a 2-entry main/skid buffer keeps full rate under backpressure.
module imm_ext_pipe #(
  parameter int IN_W  = 11,
  parameter int OUT_W = 16,
  parameter int W0    = 5,
  parameter int W1    = 8,
  parameter int W2    = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_len_sel,
  input  logic             in_sign,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_imm
);

  logic [OUT_W-1:0] main_q, main_d;
  logic [OUT_W-1:0] skid_q, skid_d;
  logic             main_vld_q, main_vld_d;
  logic             skid_vld_q, skid_vld_d;

  logic [OUT_W-1:0] imm_pad;
  logic [OUT_W-1:0] mask;
  logic [OUT_W-1:0] ext;
  logic             sb;
  logic             accept;
  logic             xfer;

  assign imm_pad = OUT_W'(in_imm);

  // mask keeps the selected field; bits above it are filled with the sign bit or zero
  always_comb begin
    mask = '0;
    sb   = 1'b0;
    case (in_len_sel)
      2'd0: begin mask = ~({OUT_W{1'b1}} << W0);   sb = in_imm[W0-1];   end
      2'd1: begin mask = ~({OUT_W{1'b1}} << W1);   sb = in_imm[W1-1];   end
      2'd2: begin mask = ~({OUT_W{1'b1}} << W2);   sb = in_imm[W2-1];   end
      default: begin mask = ~({OUT_W{1'b1}} << IN_W); sb = in_imm[IN_W-1]; end
    endcase
    ext = (imm_pad & mask) | ({OUT_W{in_sign & sb}} & ~mask);
  end

  // in_ready depends only on registered state and rst, never on out_ready
  assign in_ready  = ~rst & ~skid_vld_q;
  assign out_valid = main_vld_q;
  assign out_imm   = main_q;
  assign accept    = in_valid & in_ready & ~flush;
  assign xfer      = out_valid & out_ready;

  always_comb begin
    main_d     = main_q;
    main_vld_d = main_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (flush) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (!main_vld_q) begin
      if (accept) begin
        main_d     = ext;
        main_vld_d = 1'b1;
      end
    end else if (!skid_vld_q) begin
      if (accept && xfer) begin
        main_d = ext;
      end else if (accept) begin
        skid_d     = ext;
        skid_vld_d = 1'b1;
      end else if (xfer) begin
        main_vld_d = 1'b0;
      end
    end else if (xfer) begin
      main_d     = skid_q;
      skid_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
    end
  end

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Bench for imm_ext_pipe: directed cases plus random traffic against a queue-based reference model.
module tb_imm_ext_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [10:0] in_imm;
  logic [1:0]  in_len_sel;
  logic        in_sign;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_imm;

  int n_tests = 0;
  int n_fail  = 0;
  bit mon_en  = 1'b0;

  logic [15:0] model_q[$];
  logic [15:0] xfer_log[$];
  logic [15:0] stim_q[$];

  imm_ext_pipe dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_imm     (in_imm),
    .in_len_sel (in_len_sel),
    .in_sign    (in_sign),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_imm    (out_imm)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_ext(input logic [10:0] imm, input logic [1:0] len, input logic sgn);
    int w;
    int f;
    case (len)
      2'd0: w = 5;
      2'd1: w = 8;
      default: w = 11;
    endcase
    f = int'(imm) & ((1 << w) - 1);
    if (sgn && (((f >> (w - 1)) & 1) == 1)) f = f - (1 << w);
    return 16'(f);
  endfunction

  // Transaction-level model: a FIFO of at most two results, checked every cycle
  always @(negedge clk) begin
    if (mon_en) begin
      bit mrdy, mvld, acc, xf;
      mrdy = !rst && (model_q.size() < 2);
      mvld = model_q.size() > 0;
      chk("mon_in_ready", in_ready, mrdy);
      chk("mon_out_valid", out_valid, mvld);
      if (mvld) chk("mon_out_imm", out_imm, model_q[0]);
      acc = in_valid && mrdy && !flush;
      xf  = mvld && out_ready;
      if (xf) xfer_log.push_back(out_imm);
      if (rst || flush) model_q.delete();
      else begin
        if (xf) void'(model_q.pop_front());
        if (acc) model_q.push_back(ref_ext(in_imm, in_len_sel, in_sign));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [10:0] imm, input logic [1:0] len, input logic sgn);
    in_valid   = 1'b1;
    in_imm     = imm;
    in_len_sel = len;
    in_sign    = sgn;
  endtask

  task automatic one(input string tag, input logic [10:0] imm, input logic [1:0] len,
                     input logic sgn, input logic [15:0] exp);
    drive(imm, len, sgn);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_vld"}, out_valid, 1);
    chk(tag, out_imm, exp);
    tick();
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_imm = '0;
    in_len_sel = '0; in_sign = 1'b0; out_ready = 1'b1;
    tick();
    mon_en = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_imm", out_imm, 0);
    chk("rst_in_ready", in_ready, 1);
    tick();

    // extension values
    one("ext5_s",   11'h016, 2'd0, 1'b1, 16'hFFF6);
    one("ext5_z",   11'h016, 2'd0, 1'b0, 16'h0016);
    one("ext8_s",   11'h080, 2'd1, 1'b1, 16'hFF80);
    one("ext11_s",  11'h400, 2'd2, 1'b1, 16'hFC00);
    one("ext11_z",  11'h400, 2'd2, 1'b0, 16'h0400);
    one("ext8_hi",  11'h7FF, 2'd1, 1'b1, 16'hFFFF);
    one("ext_full", 11'h5A5, 2'd3, 1'b1, 16'hFDA5);

    // backpressure: A, B fill the buffer, C stalls
    xfer_log.delete();
    out_ready = 1'b0;
    drive(11'h05, 2'd0, 1'b1); tick();
    drive(11'h1F, 2'd0, 1'b1); tick();
    drive(11'h13, 2'd0, 1'b1);
    @(negedge clk);
    chk("bp_in_ready", in_ready, 0);
    tick(); tick();
    @(negedge clk);
    chk("bp_hold_imm", out_imm, 16'h0005);
    chk("bp_hold_rdy", in_ready, 0);
    tick();
    out_ready = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    chk("bp_count", xfer_log.size(), 3);
    if (xfer_log.size() == 3) begin
      chk("bp_a", xfer_log[0], 16'h0005);
      chk("bp_b", xfer_log[1], 16'hFFFF);
      chk("bp_c", xfer_log[2], 16'hFFF3);
    end

    // streaming at full rate
    xfer_log.delete();
    stim_q.delete();
    for (int k = 0; k < 10; k++) begin
      logic sg;
      sg = 1'($urandom_range(0, 1));
      drive(11'(k * 37 + 100), 2'd1, sg);
      stim_q.push_back(ref_ext(11'(k * 37 + 100), 2'd1, sg));
      tick();
      if (k == 9) in_valid = 1'b0;
      @(negedge clk);
      chk("stream_vld", out_valid, 1);
    end
    repeat (3) tick();
    chk("stream_count", xfer_log.size(), 10);
    for (int k = 0; k < 10 && k < xfer_log.size(); k++)
      chk("stream_val", xfer_log[k], stim_q[k]);

    // flush with the buffer full and a beat offered
    xfer_log.delete();
    out_ready = 1'b0;
    drive(11'h0AA, 2'd2, 1'b0); tick();
    drive(11'h0BB, 2'd2, 1'b0); tick();
    drive(11'h0CC, 2'd2, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    out_ready = 1'b1;
    repeat (4) tick();
    chk("flush_no_output", xfer_log.size(), 0);

    // reset while full
    out_ready = 1'b0;
    drive(11'h011, 2'd0, 1'b0); tick();
    drive(11'h012, 2'd0, 1'b0); tick();
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_in_ready", in_ready, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_out_valid", out_valid, 0);
    chk("rst_mid_out_imm", out_imm, 0);
    chk("rst_mid_in_ready_after", in_ready, 1);
    tick();

    // random traffic, checked by the model every cycle
    for (int c = 0; c < 400; c++) begin
      in_valid   = 1'($urandom_range(0, 3) != 0);
      in_imm     = 11'($urandom);
      in_len_sel = 2'($urandom_range(0, 3));
      in_sign    = 1'($urandom_range(0, 1));
      out_ready  = 1'($urandom_range(0, 2) != 0);
      flush      = 1'($urandom_range(0, 19) == 0);
      tick();
    end
    in_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();
    @(negedge clk);
    chk("drain_empty", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/imm_ext_pipe.md
Name: imm_ext_pipe

Overview:
- Registered, parametrised immediate-extension stage for the 16-bit datapath.
- Generalises the fixed 5-bit sign extender: selects a 5-, 8- or 11-bit (or full-width) instruction field per transaction and sign- or zero-extends it to OUT_W.
- Sits between decode and execute behind a valid/ready handshake.
- Uses a 2-entry skid buffer so full throughput is kept under backpressure.

Parameters:
- IN_W, 11, width of the raw immediate input field; must satisfy IN_W <= OUT_W and IN_W >= W2.
- OUT_W, 16, width of the extended result.
- W0, 5, field width selected by len_sel=0.
- W1, 8, field width selected by len_sel=1.
- W2, 11, field width selected by len_sel=2; len_sel=3 selects IN_W.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  discards all buffered entries and the current input beat.
- in_valid  input  1  input beat present.
- in_ready  output  1  stage can accept an input beat.
- in_imm  input  IN_W  raw immediate; the field is in_imm[w-1:0], and upper bits are ignored.
- in_len_sel  input  2  field width select: 0=W0, 1=W1, 2=W2, 3=IN_W.
- in_sign  input  1  1 = sign-extend from bit w-1; 0 = zero-extend.
- out_valid  output  1  out_imm holds a valid result.
- out_ready  input  1  consumer accepts the result.
- out_imm  output  OUT_W  extended immediate.

Behaviour:
- Reset (rst=1 at a clock edge):
  - main_valid=0 and skid_valid=0, so out_valid=0.
  - out_imm=0.
  - in_ready is forced 0 while rst is high.
  - Reset mid-transfer drops all held entries; no partial output appears.
- Extension, combinational on the input side:
  - w = {W0,W1,W2,IN_W}[in_len_sel].
  - result[i] = in_imm[i] for i < w.
  - result[i] = (in_sign ? in_imm[w-1] : 0) for w <= i < OUT_W.
- Handshakes:
  - Input accept = in_valid & in_ready & ~flush.
  - Output transfer = out_valid & out_ready.
  - in_ready = ~rst & ~skid_valid, driven from registered state only; there is no combinational path from out_ready.
- Latency: exactly 1 cycle from input accept to out_valid when the buffer is empty.
- Storage and ordering:
  - main holds the head entry; out_imm is driven from the main register.
  - skid holds the second entry.
  - Order is strictly FIFO.
- State, encoded as (main_valid, skid_valid):
  - EMPTY (0,0): accept → ONE.
  - ONE (1,0):
    - accept & transfer → ONE, with main replaced by the new result.
    - accept & ~transfer → FULL, with the new result written to skid.
    - ~accept & transfer → EMPTY.
    - otherwise hold.
  - FULL (1,1): in_ready=0.
    - transfer → ONE, with skid moved into main.
    - otherwise hold.
  - (0,1) is illegal and unreachable.
- Simultaneous accept and transfer in ONE keeps out_valid high continuously (throughput 1 per cycle).
- Flush:
  - At the clock edge, main_valid and skid_valid are cleared.
  - An input beat presented in the flush cycle is not accepted.
  - out_valid is 0 the next cycle.
  - Flush has priority over accept and transfer.
  - Any output transfer handshaking in the flush cycle still counts as consumed by the consumer.
- When out_valid=0, out_imm keeps its last value. Verification checks out_imm only when out_valid=1.
- Stability: while out_valid=1 and out_ready=0, out_imm and out_valid do not change.

Test Plan:
1. Extension values, with out_ready=1:
   - in_imm=5'b10110, len 0, sign=1 → out_imm=16'hFFF6 one cycle later.
   - Same with sign=0 → 16'h0016.
2. Longer fields:
   - len 1, in_imm=11'h080, sign=1 → 16'hFF80.
   - len 2, in_imm=11'h400, sign=1 → 16'hFC00.
   - len 2, sign=0 → 16'h0400.
   - len 1, in_imm=11'h7FF, sign=1 → 16'hFFFF (bits above 7 ignored).
3. Backpressure: out_ready=0, send A=0x05 then B=0x1F (len 0, sign=1).
   - Both are accepted and in_ready drops to 0.
   - C stalls while held.
   - Raise out_ready → outputs 16'h0005, 16'hFFFF, then C, in order with no loss or duplication.
4. Streaming: out_ready=1, in_valid=1 for 10 cycles with incrementing values → out_valid stays high for 10 consecutive cycles starting 1 cycle later, with values matching the model.
5. Flush with the buffer full plus in_valid=1 → next cycle out_valid=0 and in_ready=1; the flushed beat never appears.
6. Reset mid-stream: rst pulsed while FULL → out_valid=0 and out_imm=0 next cycle; in_ready=0 during rst, 1 after.
